// File: rtl/fifo_fft_framer_if.sv
// fifo_fft_framer_if
// Streaming source bus carrying scaled samples from the framer to the FFT sink.
// Signals:
//   src_data  - scaled sample
//   src_valid - src_data/src_sop/src_eop are valid
//   src_ready - sink accepts the beat when valid and ready are high at a rising edge
//   src_sop   - beat is the first sample of a frame
//   src_eop   - beat is the last sample of a frame
// Modports: master = framer (source side), slave = FFT core (sink side).
interface fifo_fft_framer_if #(
  parameter int OUT_WIDTH = 16
);
  logic [OUT_WIDTH-1:0] src_data;
  logic                 src_valid;
  logic                 src_ready;
  logic                 src_sop;
  logic                 src_eop;

  modport master (
    output src_data,
    output src_valid,
    output src_sop,
    output src_eop,
    input  src_ready
  );

  modport slave (
    input  src_data,
    input  src_valid,
    input  src_sop,
    input  src_eop,
    output src_ready
  );
endinterface

// File: rtl/fifo_fft_framer.sv
// fifo_fft_framer
// Read-side consumer of the audio clock-crossing FIFO (CLK_50 domain). Pulls one
// signed sample at a time, scales it from DATA_WIDTH to OUT_WIDTH and streams it
// out as frames of FRAME_LEN samples with sop/eop markers.
// Optional build macro: FRAMER_ROUND_EN selects round-half-up with positive
// saturation instead of plain truncation when DATA_WIDTH > OUT_WIDTH.
// Ports:
//   CLK_50       - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   fifo_empty   - FIFO empty flag
//   fifo_data    - FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en - single-cycle read pulse per sample
//   enable       - allows a new frame to start (sampled at frame boundaries only)
//   src          - streaming source bus (master modport)
//   frame_done   - one-cycle pulse after the eop beat is accepted
//   frames_out   - wrapping count of completed frames
module fifo_fft_framer #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  input  logic                  enable,
  fifo_fft_framer_if.master     src,
  output logic                  frame_done,
  output logic [15:0]           frames_out
);

  localparam int                   SHIFT    = DATA_WIDTH - OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_OUT} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] idx;
  logic [OUT_WIDTH-1:0] scaled;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 sop_q;
  logic                 eop_q;
  logic                 valid_c;
  logic                 beat_accepted;

  // Sample scaling from the FIFO width down to the stream width.
  generate
    if (SHIFT == 0) begin : g_pass
      assign scaled = fifo_data;
    end else begin : g_scale
`ifdef FRAMER_ROUND_EN
      // Adding the first dropped bit can only overflow upward from the most
      // positive value, so saturation only has to clamp to the positive max.
      logic [OUT_WIDTH:0] rounded;
      assign rounded = {fifo_data[DATA_WIDTH-1], fifo_data[DATA_WIDTH-1:SHIFT]}
                     + {{OUT_WIDTH{1'b0}}, fifo_data[SHIFT-1]};
      assign scaled  = (rounded[OUT_WIDTH] != rounded[OUT_WIDTH-1])
                     ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                     : rounded[OUT_WIDTH-1:0];
`else
      assign scaled = fifo_data[DATA_WIDTH-1:SHIFT];
`endif
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. enable only gates the start of a frame (idx == 0); once a
  // frame has begun it runs to completion regardless of enable.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty && ((idx != '0) || enable)) state_next = S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = S_OUT;
      S_OUT:   if (src.src_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded directly from the state.
  always_comb begin
    fifo_read_en = 1'b0;
    valid_c      = 1'b0;
    case (state)
      S_READ:  fifo_read_en = 1'b1;
      S_OUT:   valid_c      = 1'b1;
      default: ;
    endcase
  end

  assign beat_accepted = valid_c & src.src_ready;

  // Output beat register: captured while the FIFO data is valid and held
  // unchanged through any backpressure until the beat is accepted.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else if (state == S_WAIT) begin
      data_q <= scaled;
      sop_q  <= (idx == '0);
      eop_q  <= (idx == LAST_IDX);
    end
  end

  // Sample index and frame bookkeeping, advanced only on accepted beats.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      frame_done <= 1'b0;
      frames_out <= '0;
    end else begin
      frame_done <= beat_accepted & eop_q;
      if (beat_accepted) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + CNT_WIDTH'(1);
        if (eop_q) begin
          frames_out <= frames_out + 16'd1;
        end
      end
    end
  end

  assign src.src_data  = data_q;
  assign src.src_valid = valid_c;
  assign src.src_sop   = sop_q;
  assign src.src_eop   = eop_q;

endmodule

// File: tb/tb_fifo_fft_framer.sv
// tb_fifo_fft_framer
// Self-checking bench for fifo_fft_framer with FRAME_LEN=8. A queue-based FIFO
// feeds the design; a scoreboard of pushed samples predicts every presented beat
// (scaled data, sop/eop from the beat's position in the frame) and the frame
// counters. Works for both the default and the FRAMER_ROUND_EN build.
module tb_fifo_fft_framer;

  localparam int DW    = 24;
  localparam int OW    = 16;
  localparam int FL    = 8;
  localparam int CW    = 3;
  localparam int SHIFT = DW - OW;

  logic          CLK_50     = 1'b0;
  logic          reset      = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_read_en;
  logic          enable     = 1'b0;
  logic          frame_done;
  logic [15:0]   frames_out;

  fifo_fft_framer_if #(.OUT_WIDTH(OW)) bus ();

  fifo_fft_framer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .FRAME_LEN (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK_50      (CLK_50),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .enable      (enable),
    .src         (bus),
    .frame_done  (frame_done),
    .frames_out  (frames_out)
  );

  always #10 CLK_50 = ~CLK_50;

  int            checks            = 0;
  int            failures          = 0;
  int            cycle             = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            beat_cnt          = 0;
  int            accepts           = 0;
  int            rd_pulses         = 0;
  int            done_pulses       = 0;
  int            last_accept_cycle = 0;
  int            beat_gap          = 0;
  logic [15:0]   frames_exp        = '0;
  logic          done_pending      = 1'b0;
  logic          prev_rd           = 1'b0;
  logic [OW-1:0] last_data         = '0;
  logic          last_sop          = 1'b0;
  logic          last_eop          = 1'b0;

  // Count each comparison and report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference scaling using signed integer arithmetic.
  function automatic logic [OW-1:0] scaleRef(input logic [DW-1:0] x);
    int sx;
    int r;
    sx = int'({{(32-DW){x[DW-1]}}, x});
`ifdef FRAMER_ROUND_EN
    r = (sx + (1 << (SHIFT - 1))) >>> SHIFT;
    if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
`else
    r = sx >>> SHIFT;
`endif
    return OW'(r);
  endfunction

  // Cycle counter used for latency and beat-spacing measurements.
  always @(posedge CLK_50) cycle <= cycle + 1;

  // Behavioural FIFO: data appears the cycle after a read pulse; the empty
  // flag reflects the queue as of the last rising edge.
  always @(posedge CLK_50) begin
    if (fifo_read_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard monitor, sampled on the falling edge where everything is stable.
  always @(negedge CLK_50) begin
    if (!reset) begin
      exp_q.delete();
      beat_cnt     = 0;
      frames_exp   = '0;
      done_pending = 1'b0;
      prev_rd      = 1'b0;
    end else begin
      checkOutput("frame_done", 32'(frame_done), 32'(done_pending));
      checkOutput("frames_out", 32'(frames_out), 32'(frames_exp));
      if (frame_done) done_pulses++;
      done_pending = 1'b0;
      if (fifo_read_en) begin
        rd_pulses++;
        checkOutput("rd_single", 32'(prev_rd), 32'd0);
        checkOutput("rd_nonempty", 32'(fifo_empty), 32'd0);
        checkOutput("rd_while_valid", 32'(bus.src_valid), 32'd0);
      end
      prev_rd = fifo_read_en;
      if (bus.src_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'(bus.src_valid), 32'd0);
        end else begin
          checkOutput("src_data", 32'(bus.src_data), 32'(scaleRef(exp_q[0])));
          checkOutput("src_sop", 32'(bus.src_sop), 32'((beat_cnt % FL) == 0));
          checkOutput("src_eop", 32'(bus.src_eop), 32'((beat_cnt % FL) == FL - 1));
          if (bus.src_ready) begin
            last_data         = bus.src_data;
            last_sop          = bus.src_sop;
            last_eop          = bus.src_eop;
            beat_gap          = cycle - last_accept_cycle;
            last_accept_cycle = cycle;
            accepts++;
            if ((beat_cnt % FL) == FL - 1) begin
              frames_exp   = frames_exp + 16'd1;
              done_pending = 1'b1;
            end
            beat_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  // Push one sample into the FIFO and the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] sample);
    fifo_q.push_back(sample);
    exp_q.push_back(sample);
  endtask

  task automatic waitAccepts(input int target, input int budget);
    for (int i = 0; i < budget && accepts < target; i++) tick(1);
    if (accepts < target) checkOutput("accept_timeout", 32'(accepts), 32'(target));
  endtask

  task automatic waitValid(input int budget);
    for (int i = 0; i < budget && !bus.src_valid; i++) tick(1);
    if (!bus.src_valid) checkOutput("valid_timeout", 32'(bus.src_valid), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.src_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(bus.src_data), 32'd0);
    checkOutput({tag, "_sop"}, 32'(bus.src_sop), 32'd0);
    checkOutput({tag, "_eop"}, 32'(bus.src_eop), 32'd0);
    checkOutput({tag, "_rd"}, 32'(fifo_read_en), 32'd0);
    checkOutput({tag, "_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_frames"}, 32'(frames_out), 32'd0);
  endtask

  // Watchdog so the run always ends with a summary.
  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [DW-1:0] scl_in [4];
    logic [OW-1:0] scl_exp[4];
    int base;
    int rd0;
    int t0;
    int pushed;
    logic [15:0] fbefore;

    scl_in = '{24'h7FFFFF, 24'h000080, 24'hFFFF80, 24'h800000};
`ifdef FRAMER_ROUND_EN
    scl_exp = '{16'h7FFF, 16'h0001, 16'h0000, 16'h8000};
`else
    scl_exp = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
`endif

    bus.src_ready = 1'b0;
    $display("[TB] reset and idle");
    tick(3);
    checkAllZero("rst");
    reset  = 1'b1;
    enable = 1'b1;
    tick(50);
    checkAllZero("idle");
    checkOutput("idle_rd_pulses", 32'(rd_pulses), 32'd0);

    $display("[TB] single frame, latency and throughput");
    bus.src_ready = 1'b1;
    base = accepts;
    for (int i = 1; i <= FL; i++) applyStimulus(DW'(i * 'h100));
    for (int i = 0; i < 10 && fifo_empty; i++) begin @(negedge CLK_50); #1; end
    t0 = cycle;
    for (int i = 0; i < 10 && !bus.src_valid; i++) begin @(negedge CLK_50); #1; end
    checkOutput("latency", 32'(cycle - t0), 32'd3);
    for (int b = 1; b <= FL; b++) begin
      waitAccepts(base + b, 20);
      checkOutput("frame_data", 32'(last_data), 32'(b));
      if (b > 1) checkOutput("beat_gap", 32'(beat_gap), 32'd4);
    end
    tick(2);
    checkOutput("frame_frames", 32'(frames_out), 32'd1);
    checkOutput("frame_done_cnt", 32'(done_pulses), 32'd1);

    $display("[TB] backpressure");
    bus.src_ready = 1'b0;
    applyStimulus(DW'($urandom));
    waitValid(20);
    rd0 = rd_pulses;
    base = accepts;
    tick(20);
    checkOutput("bp_rd", 32'(rd_pulses), 32'(rd0));
    checkOutput("bp_valid", 32'(bus.src_valid), 32'd1);
    bus.src_ready = 1'b1;
    waitAccepts(base + 1, 5);
    checkOutput("bp_idle_valid", 32'(bus.src_valid), 32'd0);
    checkOutput("bp_idle_rd", 32'(fifo_read_en), 32'd0);
    base = accepts;
    for (int i = 1; i < FL; i++) applyStimulus(DW'($urandom));
    waitAccepts(base + FL - 1, 60);

    $display("[TB] enable gating");
    fbefore = frames_out;
    base = accepts;
    for (int i = 0; i < FL; i++) applyStimulus(DW'($urandom));
    waitAccepts(base + 3, 30);
    enable = 1'b0;
    waitAccepts(base + FL, 60);
    tick(1);
    checkOutput("gate_frames", 32'(frames_out), 32'(fbefore + 16'd1));
    checkOutput("gate_eop", 32'(last_eop), 32'd1);
    rd0 = rd_pulses;
    for (int i = 0; i < 4; i++) applyStimulus(DW'($urandom));
    tick(30);
    checkOutput("gate_no_read", 32'(rd_pulses), 32'(rd0));
    checkOutput("gate_no_valid", 32'(bus.src_valid), 32'd0);
    enable = 1'b1;
    base = accepts;
    waitAccepts(base + 1, 20);
    checkOutput("gate_sop", 32'(last_sop), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(DW'($urandom));
    waitAccepts(base + FL, 60);

    $display("[TB] scaling");
    base = accepts;
    for (int i = 0; i < 4; i++) applyStimulus(scl_in[i]);
    for (int i = 4; i < FL; i++) applyStimulus(DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      waitAccepts(base + i + 1, 20);
      checkOutput("scale", 32'(last_data), 32'(scl_exp[i]));
    end
    waitAccepts(base + FL, 40);

    $display("[TB] randomized traffic");
    base   = accepts;
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      bus.src_ready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      if (pushed < 3 * FL && $urandom_range(0, 4) == 0) begin
        applyStimulus(DW'($urandom));
        pushed++;
      end
      tick(1);
    end
    while (pushed < 3 * FL) begin
      applyStimulus(DW'($urandom));
      pushed++;
    end
    bus.src_ready = 1'b1;
    enable        = 1'b1;
    waitAccepts(base + 3 * FL, 200);
    tick(2);
    checkOutput("rand_frames", 32'(frames_out), 32'(frames_exp));

    $display("[TB] reset mid-frame");
    base = accepts;
    for (int i = 0; i < FL; i++) applyStimulus(DW'($urandom));
    waitAccepts(base + 5, 40);
    waitValid(10);
    reset = 1'b0;
    #1;
    checkAllZero("rst_mid");
    fifo_q.delete();
    tick(3);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_frames", 32'(frames_out), 32'd0);
    base = accepts;
    for (int i = 0; i < FL; i++) applyStimulus(DW'($urandom));
    waitAccepts(base + 1, 20);
    checkOutput("rst_sop", 32'(last_sop), 32'd1);
    waitAccepts(base + FL, 60);
    tick(2);
    checkOutput("rst_frame_count", 32'(frames_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
